// File: rtl/vx_gpu_pkg.sv
// Shared dispatch-arbiter types: lock state encoding and selector width helpers.
package vx_gpu_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int PERF_CTR_BITS = 32;

    function automatic int dispatch_sel_w(input int num_reqs);
        return (num_reqs > 1) ? $clog2(num_reqs) : 1;
    endfunction

    localparam int DISPATCH_SEL_W = dispatch_sel_w(4);

endpackage

// File: rtl/vx_dispatch_rr_sel.sv
// Rotate-priority selector: picks the first set mask bit at or after rr_ptr, wrapping.
module vx_dispatch_rr_sel
    import vx_gpu_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int SEL_W    = dispatch_sel_w(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] mask,
    input  logic [SEL_W-1:0]    rr_ptr,
    output logic [SEL_W-1:0]    grant_idx,
    output logic                grant_vld
);

    // Walk from farthest to nearest so the candidate closest to rr_ptr wins last.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (mask[(int'(rr_ptr) + i) % NUM_REQS]) begin
                grant_vld = 1'b1;
                grant_idx = SEL_W'((int'(rr_ptr) + i) % NUM_REQS);
            end
        end
    end

endmodule

// File: rtl/vx_dispatch_arb.sv
// Packet-locking round-robin dispatch arbiter with a single registered output beat.
// Optional stall counter output perf_stalls when DISPATCH_ARB_PERF_EN is defined.
module vx_dispatch_arb
    import vx_gpu_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 64,
    localparam int SEL_W   = dispatch_sel_w(NUM_REQS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQS-1:0]            valid_in,
    input  logic [NUM_REQS-1:0][DATAW-1:0] data_in,
    input  logic [NUM_REQS-1:0]            last_in,
    output logic [NUM_REQS-1:0]            ready_in,
    output logic                           valid_out,
    output logic [DATAW-1:0]               data_out,
    output logic                           last_out,
    output logic [SEL_W-1:0]               sel_out,
    input  logic                           ready_out
`ifdef DISPATCH_ARB_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0]       perf_stalls
`endif
);

    localparam logic [NUM_REQS-1:0] ONE_HOT0 = NUM_REQS'(1);

    arb_state_e             state_p1, state_p0;
    logic [SEL_W-1:0]       lock_idx_p1, lock_idx_p0;
    logic [SEL_W-1:0]       rr_ptr_p1, rr_ptr_p0;
    logic [NUM_REQS-1:0]    mask_p0;
    logic [SEL_W-1:0]       sel_ptr_p0;
    logic [SEL_W-1:0]       grant_idx_p0;
    logic                   grant_vld_p0;
    logic                   stage_ready_p0;
    logic                   xfer_p0;

    logic                   vld_p1;
    logic [DATAW-1:0]       data_p1;
    logic                   last_p1;
    logic [SEL_W-1:0]       sel_p1;

    // ---- p0: grant selection (combinational) ----
    assign stage_ready_p0 = ~vld_p1 | ready_out;
    assign mask_p0    = (state_p1 == ARB_LOCKED) ? (valid_in & (ONE_HOT0 << lock_idx_p1)) : valid_in;
    assign sel_ptr_p0 = (state_p1 == ARB_LOCKED) ? lock_idx_p1 : rr_ptr_p1;

    vx_dispatch_rr_sel #(
        .NUM_REQS (NUM_REQS),
        .SEL_W    (SEL_W)
    ) u_rr_sel (
        .mask      (mask_p0),
        .rr_ptr    (sel_ptr_p0),
        .grant_idx (grant_idx_p0),
        .grant_vld (grant_vld_p0)
    );

    assign xfer_p0  = grant_vld_p0 & stage_ready_p0 & ~reset;
    assign ready_in = xfer_p0 ? (ONE_HOT0 << grant_idx_p0) : '0;

    always_comb begin
        state_p0    = state_p1;
        lock_idx_p0 = lock_idx_p1;
        rr_ptr_p0   = rr_ptr_p1;
        if (xfer_p0) begin
            if (last_in[grant_idx_p0]) begin
                state_p0  = ARB_IDLE;
                rr_ptr_p0 = (grant_idx_p0 == SEL_W'(NUM_REQS - 1)) ? '0 : grant_idx_p0 + SEL_W'(1);
            end else begin
                state_p0    = ARB_LOCKED;
                lock_idx_p0 = grant_idx_p0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_p1    <= ARB_IDLE;
            lock_idx_p1 <= '0;
            rr_ptr_p1   <= '0;
        end else begin
            state_p1    <= state_p0;
            lock_idx_p1 <= lock_idx_p0;
            rr_ptr_p1   <= rr_ptr_p0;
        end
    end

    // ---- p1: registered output beat ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
            sel_p1  <= '0;
        end else if (xfer_p0) begin
            vld_p1  <= 1'b1;
            data_p1 <= data_in[grant_idx_p0];
            last_p1 <= last_in[grant_idx_p0];
            sel_p1  <= grant_idx_p0;
        end else if (ready_out) begin
            vld_p1  <= 1'b0;
        end
    end

    assign valid_out = vld_p1;
    assign data_out  = data_p1;
    assign last_out  = last_p1;
    assign sel_out   = sel_p1;

`ifdef DISPATCH_ARB_PERF_EN
    logic [PERF_CTR_BITS-1:0] stall_cnt_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_p1 <= '0;
        end else if ((|valid_in) && !xfer_p0) begin
            stall_cnt_p1 <= stall_cnt_p1 + PERF_CTR_BITS'(1);
        end
    end

    assign perf_stalls = stall_cnt_p1;
`endif

endmodule

// File: tb/tb_vx_dispatch_arb.sv
// Directed table-driven bench for vx_dispatch_arb plus reset and stall sequences.
module tb_vx_dispatch_arb;
    import vx_gpu_pkg::*;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int SW = 2;
    localparam int NV = 27;

    logic                   clk;
    logic                   reset;
    logic [N-1:0]           valid_in;
    logic [N-1:0][DW-1:0]   data_in;
    logic [N-1:0]           last_in;
    logic [N-1:0]           ready_in;
    logic                   valid_out;
    logic [DW-1:0]          data_out;
    logic                   last_out;
    logic [SW-1:0]          sel_out;
    logic                   ready_out;
`ifdef DISPATCH_ARB_PERF_EN
    logic [PERF_CTR_BITS-1:0] perf_stalls;
    logic [PERF_CTR_BITS-1:0] perf_snap;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    vx_dispatch_arb #(
        .NUM_REQS (N),
        .DATAW    (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .last_in   (last_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .last_out  (last_out),
        .sel_out   (sel_out),
        .ready_out (ready_out)
`ifdef DISPATCH_ARB_PERF_EN
        ,
        .perf_stalls (perf_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  valid;
        logic [N-1:0]  last;
        logic          rdy_out;
        logic [N-1:0]  exp_rdy_in;
        logic          exp_vld;
        logic [SW-1:0] exp_sel;
        logic          exp_last;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[NV];

    function automatic vec_t mk(input logic [N-1:0] v, input logic [N-1:0] l, input logic ro,
                                input logic [N-1:0] eri, input logic ev, input logic [SW-1:0] es,
                                input logic el, input logic [DW-1:0] ed);
        vec_t r;
        r.valid = v; r.last = l; r.rdy_out = ro; r.exp_rdy_in = eri;
        r.exp_vld = ev; r.exp_sel = es; r.exp_last = el; r.exp_data = ed;
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %h want %h", name, idx, got, exp);
        end
    endtask

    // Payload of requester i is {i, stp} so data_out identifies source and cycle.
    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic ro, input logic [7:0] stp);
        valid_in  = v;
        last_in   = l;
        ready_out = ro;
        for (int i = 0; i < N; i++) data_in[i] = {8'(i), stp};
    endtask

    initial begin
        vecs[0]  = mk(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 16'h0000);
        vecs[1]  = mk(4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 16'h0101);
        vecs[2]  = mk(4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 16'h0202);
        vecs[3]  = mk(4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 16'h0303);
        vecs[4]  = mk(4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 16'h0004);
        vecs[5]  = mk(4'b0111, 4'b0101, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 16'h0105);
        vecs[6]  = mk(4'b0111, 4'b0101, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 16'h0106);
        vecs[7]  = mk(4'b0111, 4'b0101, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 16'h0107);
        vecs[8]  = mk(4'b0111, 4'b0111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 16'h0108);
        vecs[9]  = mk(4'b0101, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 16'h0209);
        vecs[10] = mk(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 16'h000A);
        vecs[11] = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 16'h0000);
        vecs[12] = mk(4'b1010, 4'b1000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 16'h010C);
        vecs[13] = mk(4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 16'h0000);
        vecs[14] = mk(4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 16'h0000);
        vecs[15] = mk(4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 16'h0000);
        vecs[16] = mk(4'b1010, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 16'h0110);
        vecs[17] = mk(4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 16'h0311);
        vecs[18] = mk(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 16'h0012);
        for (int k = 19; k <= 23; k++)
            vecs[k] = mk(4'b0011, 4'b0011, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 16'h0012);
        vecs[24] = mk(4'b0011, 4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 16'h0118);
        vecs[25] = mk(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 16'h0019);
        vecs[26] = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 16'h0000);

        reset = 1'b1;
        drive('0, '0, 1'b1, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_out", 0, 32'(valid_out), 32'h0);
        check("rst_ready_in",  0, 32'(ready_in),  32'h0);
        check("rst_data_out",  0, 32'(data_out),  32'h0);
        check("rst_last_out",  0, 32'(last_out),  32'h0);
        check("rst_sel_out",   0, 32'(sel_out),   32'h0);
        reset = 1'b0;

        for (int k = 0; k < NV; k++) begin
            drive(vecs[k].valid, vecs[k].last, vecs[k].rdy_out, 8'(k));
            #1;
            check("ready_in", k, 32'(ready_in), 32'(vecs[k].exp_rdy_in));
            @(posedge clk);
            #1;
            check("valid_out", k, 32'(valid_out), 32'(vecs[k].exp_vld));
            if (vecs[k].exp_vld) begin
                check("sel_out",  k, 32'(sel_out),  32'(vecs[k].exp_sel));
                check("last_out", k, 32'(last_out), 32'(vecs[k].exp_last));
                check("data_out", k, 32'(data_out), 32'(vecs[k].exp_data));
            end
        end

        // Reset on beat 2 of a req2 packet: lock and held beat must be discarded.
        drive(4'b0100, 4'b0000, 1'b1, 8'h40);
        #1;
        check("mid_rst_b1_ready", 0, 32'(ready_in), 32'h4);
        @(posedge clk);
        #1;
        check("mid_rst_b1_sel", 0, 32'(sel_out), 32'h2);
        drive(4'b0100, 4'b0000, 1'b1, 8'h41);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 0, 32'(ready_in), 32'h0);
        @(posedge clk);
        #1;
        check("mid_rst_valid_out", 0, 32'(valid_out), 32'h0);
        check("mid_rst_data_out",  0, 32'(data_out),  32'h0);
        reset = 1'b0;
        drive(4'b0101, 4'b0101, 1'b1, 8'h42);
        #1;
        check("post_rst_ready", 0, 32'(ready_in), 32'h1);
        @(posedge clk);
        #1;
        check("post_rst_sel",  0, 32'(sel_out),  32'h0);
        check("post_rst_data", 0, 32'(data_out), 32'h0042);

`ifdef DISPATCH_ARB_PERF_EN
        // Fill the output, then stall downstream for 10 cycles with req0 pending.
        drive(4'b0001, 4'b0001, 1'b1, 8'h50);
        @(posedge clk);
        #1;
        perf_snap = perf_stalls;
        check("perf_fill_data", 0, 32'(data_out), 32'h0050);
        drive(4'b0001, 4'b0001, 1'b0, 8'h51);
        repeat (10) @(posedge clk);
        #1;
        check("perf_stalls_delta", 0, 32'(perf_stalls - perf_snap), 32'd10);
        check("perf_hold_data",    0, 32'(data_out), 32'h0050);
        drive(4'b0000, 4'b0000, 1'b1, 8'h52);
        @(posedge clk);
        #1;
`endif

        drive('0, '0, 1'b1, 8'h00);
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
